// File: rtl/pipeline_max_pkg.sv
// ============================================================================
// pipeline_max_pkg: shared types and helpers for the pipelined max unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_max_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/max_client_tx_if.sv
// ============================================================================
// max_client_tx_if: client-side valid/ready stream into the max unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface max_client_tx_if
    import pipeline_max_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  client_val;
    logic                  client_rdy;
    logic [DATA_WIDTH-1:0] client_data;
    logic                  client_last;

    modport master (
        output client_val,
        output client_data,
        output client_last,
        input  client_rdy
    );

    modport slave (
        input  client_val,
        input  client_data,
        input  client_last,
        output client_rdy
    );
endinterface

`default_nettype wire

// File: rtl/max_client_tx_buffer.sv
// ============================================================================
// tx_buffer: circular sample store with occupancy count and full flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_buffer
    import pipeline_max_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 8,
    localparam int AW         = clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  rd_adv,
    output logic      [DATA_WIDTH-1:0] rd_data,
    output logic      [CW-1:0]         count,
    output logic                       full
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_wr;

    // full comes from the registered count, so a same-cycle read never frees a slot
    assign w_wr    = wr_en && !full;
    assign full    = (r_count == CW'(DEPTH));
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, rd_adv})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/max_client_tx.sv
// ============================================================================
// max_client_tx: buffered burst transmitter driving the max unit client port
// Revision: 1.0
// ============================================================================
`default_nettype none

module max_client_tx
    import pipeline_max_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 8,
    localparam int CW         = clog2(DEPTH) + 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    output logic                       full,
    output logic      [CW-1:0]         count,
    input  wire logic                  start,
    input  wire logic [CW-1:0]         len,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    max_client_tx_if.master            client
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_remaining;
    logic                  r_err;
    logic                  w_xfer;
    logic                  w_sending;
    logic [DATA_WIDTH-1:0] w_rd_data;

    tx_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_adv  (w_xfer),
        .rd_data (w_rd_data),
        .count   (count),
        .full    (full)
    );

    // Outputs decode straight from state so an async reset drops client_val at once
    assign w_sending          = (r_state == ST_SEND);
    assign w_xfer             = w_sending && client.client_rdy;
    assign client.client_val  = w_sending;
    assign client.client_data = w_sending ? w_rd_data : '0;
    assign client.client_last = w_sending && (r_remaining == CW'(1));
    assign busy               = (r_state != ST_IDLE);
    assign done               = (r_state == ST_DONE);
    assign err                = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if ((len == '0) || (len > count)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_remaining <= len;
                            r_state     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - CW'(1);
                        if (r_remaining == CW'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_max_client_tx.sv
// ============================================================================
// tb_max_client_tx: directed + random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_max_client_tx;
    import pipeline_max_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          full, busy, done, err;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    max_client_tx_if #(.DATA_WIDTH(DW)) cif ();

    max_client_tx #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .count   (count),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .client  (cif)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: buffer as a FIFO queue, burst as "words left to send"
    logic [DW-1:0] m_q[$];
    bit            m_active;
    bit            m_done;
    bit            m_err;
    int            m_rem;
    logic [DW-1:0] sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_active = 0;
        m_done   = 0;
        m_err    = 0;
        m_rem    = 0;
    endtask

    task automatic step();
        bit xfer, ok_wr, n_active, n_done, n_err;
        int n_rem;
        chk("client_val",  32'(cif.client_val),  32'(m_active));
        chk("client_data", 32'(cif.client_data), m_active ? 32'(m_q[0]) : 32'd0);
        chk("client_last", 32'(cif.client_last), 32'(m_active && m_rem == 1));
        chk("busy",        32'(busy),            32'(m_active || m_done));
        chk("done",        32'(done),            32'(m_done));
        chk("err",         32'(err),             32'(m_err));
        chk("count",       32'(count),           32'(m_q.size()));
        chk("full",        32'(full),            32'(m_q.size() == DEPTH));
        n_active = m_active;
        n_rem    = m_rem;
        n_done   = 0;
        n_err    = 0;
        ok_wr    = wr_en && (m_q.size() < DEPTH);
        xfer     = m_active && cif.client_rdy;
        if (!m_active && !m_done && start) begin
            if (len == 0 || int'(len) > m_q.size()) n_err = 1;
            else begin
                n_active = 1;
                n_rem    = int'(len);
            end
        end
        if (xfer) begin
            sent.push_back(m_q.pop_front());
            n_rem--;
            if (n_rem == 0) begin
                n_active = 0;
                n_done   = 1;
            end
        end
        if (ok_wr) m_q.push_back(wr_data);
        @(posedge clk);
        #1;
        m_active = n_active;
        m_rem    = n_rem;
        m_done   = n_done;
        m_err    = n_err;
    endtask

    task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit st, input int ln, input bit rdy);
        wr_en          = we;
        wr_data        = wd;
        start          = st;
        len            = CW'(ln);
        cif.client_rdy = rdy;
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_client_val", 32'(cif.client_val), 32'd0);
        model_clear();
        repeat (n) @(posedge clk);
        #1;
        rst            = 1'b0;
        wr_en          = 0;
        start          = 0;
        len            = '0;
        cif.client_rdy = 0;
    endtask

    task automatic load4();
        cyc(1, 8'h12, 0, 0, 0);
        cyc(1, 8'hFA, 0, 0, 0);
        cyc(1, 8'h07, 0, 0, 0);
        cyc(1, 8'h80, 0, 0, 0);
    endtask

    task automatic chk_sent4(input string name);
        chk({name, "_n"},  32'(sent.size()), 32'd4);
        if (sent.size() == 4) begin
            chk({name, "_w0"}, 32'(sent[0]), 32'h12);
            chk({name, "_w1"}, 32'(sent[1]), 32'hFA);
            chk({name, "_w2"}, 32'(sent[2]), 32'h07);
            chk({name, "_w3"}, 32'(sent[3]), 32'h80);
        end
    endtask

    initial begin
        bit bp[4] = '{1, 0, 0, 1};
        cif.client_rdy = 0;
        #1;
        do_reset(2);
        repeat (10) cyc(0, 0, 0, 0, 0);
        chk("idle_count", 32'(count), 32'd0);

        // basic burst
        sent.delete();
        load4();
        cyc(0, 0, 1, 4, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);
        chk_sent4("basic");
        chk("basic_count", 32'(count), 32'd0);

        // backpressure
        sent.delete();
        load4();
        cyc(0, 0, 1, 4, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, bp[i % 4]);
        chk_sent4("bp");

        // full, wrap and reject
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1, DW'(i * 17 + 3), 0, 0, 0);
        cyc(1, 8'hEE, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("full_flag",  32'(full),  32'd1);
        chk("full_count", 32'(count), 32'd8);
        cyc(0, 0, 1, 5, 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, DW'(8'hA0 + i), 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_count", 32'(count), 32'd8);
        cyc(0, 0, 1, 9, 0);
        chk("len9_err",  32'(err),  32'd1);
        chk("len9_busy", 32'(busy), 32'd0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // rejects
        cyc(0, 0, 1, 0, 0);
        chk("len0_err", 32'(err), 32'd1);
        sent.delete();
        cyc(0, 0, 1, 3, 1);
        cyc(0, 0, 1, 1, 1);
        chk("ignored_err", 32'(err), 32'd0);
        repeat (4) cyc(0, 0, 0, 0, 1);
        chk("ignored_sent", 32'(sent.size()), 32'd3);

        // reset mid-burst
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1, DW'(i + 1), 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 0);
        chk("pre_rst_val", 32'(cif.client_val), 32'd1);
        do_reset(1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_done",  32'(done),  32'd0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 4) == 0,
                $urandom_range(0, 9), $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/max_client_tx.md
# max_client_tx

Buffered stream transmitter for the client side of the pipelined max unit. Software-side logic loads samples into a small circular buffer. A start command then streams a chosen number of them over the client valid/ready handshake (`client_val`/`client_rdy`/`client_data`) into the max unit, with a last marker on the final word. It sits directly upstream of the max pipeline and drives its client port.

## Interface
- `DATA_WIDTH`, 8, sample width; matches the max unit data width.
- `DEPTH`, 8, buffer entries; power of two, ≥ 2.
- `CW` = clog2(DEPTH)+1 (derived): width of count and length fields.

- `clk`  in  1  rising-edge clock (single clock domain).
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  load strobe; writes `wr_data` into the buffer.
- `wr_data`  in  DATA_WIDTH  sample to load.
- `full`  out  1  buffer holds DEPTH samples.
- `count`  out  CW  samples currently stored.
- `start`  in  1  begin a burst of `len` samples.
- `len`  in  CW  burst length; sampled only on an accepted start.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a burst ends.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `client_val`  out  1  `client_data` valid.
- `client_rdy`  in  1  downstream accepts.
- `client_data`  out  DATA_WIDTH  current sample; 0 when `client_val`=0.
- `client_last`  out  1  current word is the final word of the burst.

## Operation
- **Buffer.** Circular, with `wr_ptr`, `rd_ptr` and `count`.
  - A write happens when `wr_en` && !`full`. The write goes to `mem[wr_ptr]`, then `wr_ptr`++ (wraps at DEPTH).
  - `wr_en` while `full` is dropped silently. `full` is taken from the registered `count`, so a write is rejected even when a read occurs in the same cycle.
  - A write and a transfer in the same cycle leave `count` unchanged; both pointers advance.
  - Writes are legal in any state.
- **FSM `tx_state_t`:**
  - **IDLE.** `start` with 1 ≤ `len` ≤ `count`: latch `remaining` = `len`, go to SEND.
    - `len`=0 or `len` > `count`: pulse `err`, stay in IDLE.
  - **SEND.** `client_val`=1 and `client_data`=`mem[rd_ptr]`.
    - Transfer = `client_val` && `client_rdy`.
    - On each transfer: `rd_ptr`++ (wraps), `count`--, `remaining`--.
    - `client_last`=1 while `remaining`=1.
    - A transfer with `remaining`=1 moves the FSM to DONE.
  - **DONE.** `done`=1 for this cycle, `client_val`=0; next state is IDLE.
- `start` is ignored without `err` while `busy`.
- **Data stability.** `rd_ptr` moves only on a transfer. `client_data` and `client_last` therefore hold while `client_val` && !`client_rdy`, and `client_val` never drops mid-burst.
- **Reset values.** While `rst` is high:
  - state IDLE; pointers, `count` and `remaining` cleared;
  - `client_val`, `client_last`, `busy`, `done`, `err` and `full` are 0; `client_data` is 0.
  - Buffer contents are don't-care.
- **Reset mid-burst.** `client_val` drops immediately (asynchronous) and the burst is abandoned with no `done` pulse.

## Timing
- An accepted `start` at edge N raises `client_val` in the cycle after edge N (1-cycle latency).
- With `client_rdy` held at 1, one word is transferred per cycle. `client_val` stays high for exactly `len` cycles, and `done` pulses in the cycle after the last transfer.
- `err` pulses in the cycle after the rejected start edge.
- **Minimum turnaround.** After `done`, a new `start` is accepted at the next edge: burst, DONE, IDLE. That is one dead cycle between bursts beyond the DONE cycle.
- `full` and `count` update on the edge after the write or transfer.

## Structure
- Shared package `pipeline_max_pkg` holds:
  - `tx_state_t` enum {IDLE, SEND, DONE};
  - the `clog2` function;
  - the default `DATA_WIDTH` constant, shared with the max unit.
- Sub-module `tx_buffer` contains:
  - the circular memory, both pointers, `count` and `full`;
  - ports: write port, read-advance strobe, read data.
- The top level holds the FSM, `remaining`, and the handshake outputs.

## Test plan
- **Reset then idle.** Assert `rst` for 2 cycles, then release. Required: all outputs 0, `count`=0, no `client_val` for 10 cycles.
- **Basic burst.** Load 0x12, 0xFA, 0x07, 0x80 and pulse `start` with `len`=4, `client_rdy`=1. Required:
  - `client_data` sequence 0x12, 0xFA, 0x07, 0x80 on 4 consecutive cycles;
  - `client_last` only on 0x80;
  - `done` one cycle later; `count`=0.
- **Backpressure.** Same load, with `client_rdy` toggling 1,0,0,1,… Required: each word holds stable until accepted; total 4 transfers; order preserved.
- **Full, wrap and reject.**
  - Load 8 words, then a 9th. Required: 9th dropped, `full`=1, `count`=8.
  - Burst `len`=5 concurrent with 5 new writes. Required: pointers wrap, `count`=8.
  - `start` with `len`=9. Required: `err` pulse, no burst.
- **Rejects.** `start` with `len`=0 → `err`. `start` during SEND → ignored, no `err`, current burst unaffected.
- **Reset mid-burst.** Assert `rst` while SEND with `client_rdy`=0. Required: `client_val` falls in the same cycle, state IDLE, `count`=0, no `done`.
